// File: rtl/hub75_scan_timer.sv
// hub75_scan_timer
//   Scan/timing generator for a HUB75 LED matrix. For every row and every
//   BCM bit plane it shifts COLS pixels, blanks, latches, blanks again, and
//   then lights the row for BASE_CYC<<plane cycles. It also hands out pixel
//   fetch addresses so the RGB pins can be driven externally.
//
//   Ports
//     clock        PLL output clock, all logic on the rising edge
//     reset        synchronous, active high
//     enable       run request, sampled only at a frame boundary
//     col_addr     column currently being shifted
//     row_addr     row whose data is being shifted
//     plane        bit plane currently being shifted
//     pix_req      1-cycle fetch strobe for {row_addr,col_addr,plane}
//     hub_clk      panel shift clock
//     hub_lat      panel latch
//     hub_oe_n     panel output enable, active low
//     hub_row      panel row select (A..E)
//     frame_start  1-cycle pulse with the first pix_req of row 0 / plane 0
//
//   Every output is a register. Each state transition loads the output values
//   for the first cycle of the state being entered, so the pins line up
//   exactly with the state register and never glitch.
module hub75_scan_timer #(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 5,
  parameter int PLANE_BITS = 3,
  parameter int CLK_HALF   = 2,
  parameter int BLANK_CYC  = 4,
  parameter int LATCH_CYC  = 2,
  parameter int BASE_CYC   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  output logic [$clog2(COLS)-1:0]   col_addr,
  output logic [ROW_BITS-1:0]       row_addr,
  output logic [PLANE_BITS-1:0]     plane,
  output logic                      pix_req,
  output logic                      hub_clk,
  output logic                      hub_lat,
  output logic                      hub_oe_n,
  output logic [ROW_BITS-1:0]       hub_row,
  output logic                      frame_start
);

  localparam int CAW      = $clog2(COLS);
  localparam int PLANES   = 1 << PLANE_BITS;
  // Longest display period; the counter must hold its terminal count, and the
  // length itself must be representable when computing it from plane.
  localparam int DISP_MAX = BASE_CYC << (PLANES - 1);
  localparam int DW       = $clog2(DISP_MAX + 1);
  // The short phase counter serves SHIFT (per column), BLANK and LATCH.
  localparam int CMAX0    = (2 * CLK_HALF > BLANK_CYC) ? 2 * CLK_HALF : BLANK_CYC;
  localparam int CMAX     = (CMAX0 > LATCH_CYC) ? CMAX0 : LATCH_CYC;
  localparam int CW       = $clog2(CMAX);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK1,
    LATCH,
    BLANK2,
    DISPLAY
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] disp_last;

  // Terminal count of the display phase for the current plane.
  assign disp_last = (DW'(BASE_CYC) << plane) - DW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dcnt        <= '0;
      col_addr    <= '0;
      row_addr    <= '0;
      plane       <= '0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      hub_clk     <= 1'b0;
      hub_lat     <= 1'b0;
      hub_oe_n    <= 1'b1;
      hub_row     <= '0;
    end else begin
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= SHIFT;
            cnt         <= '0;
            col_addr    <= '0;
            row_addr    <= '0;
            plane       <= '0;
            pix_req     <= 1'b1;
            frame_start <= 1'b1;
          end
        end

        // cnt walks 0..2*CLK_HALF-1 within one column: low half, then high half.
        SHIFT: begin
          if (cnt == CW'(2 * CLK_HALF - 1)) begin
            cnt     <= '0;
            hub_clk <= 1'b0;
            if (col_addr == CAW'(COLS - 1)) begin
              state    <= BLANK1;
              col_addr <= '0;
            end else begin
              col_addr <= col_addr + CAW'(1);
              pix_req  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(CLK_HALF - 1)) hub_clk <= 1'b1;
          end
        end

        BLANK1: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            state   <= LATCH;
            cnt     <= '0;
            hub_lat <= 1'b1;
            hub_row <= row_addr;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        LATCH: begin
          if (cnt == CW'(LATCH_CYC - 1)) begin
            state   <= BLANK2;
            cnt     <= '0;
            hub_lat <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        BLANK2: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            state    <= DISPLAY;
            cnt      <= '0;
            dcnt     <= '0;
            hub_oe_n <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DISPLAY: begin
          if (dcnt == disp_last) begin
            dcnt     <= '0;
            hub_oe_n <= 1'b1;
            plane    <= plane + PLANE_BITS'(1);
            if (&plane) row_addr <= row_addr + ROW_BITS'(1);
            // Enable is only honoured here, once the last row/plane is shown.
            if ((&plane) && (&row_addr) && !enable) begin
              state <= IDLE;
            end else begin
              state       <= SHIFT;
              cnt         <= '0;
              col_addr    <= '0;
              pix_req     <= 1'b1;
              frame_start <= (&plane) && (&row_addr);
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          hub_clk  <= 1'b0;
          hub_lat  <= 1'b0;
          hub_oe_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
